// File: rtl/nibble_serial_adder.sv
// Word-wide add/subtract unit that streams 4-bit slices through one carry-lookahead slice.
// A registered carry links consecutive slices; valid/ready handshakes on both sides.

module CarryLookAheadAdder4Bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_sum,
  output logic       o_c
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign o_c    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

  assign o_sum = w_p ^ w_c;

endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned NumSlices = WIDTH / 4;
  localparam int unsigned KW        = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [KW-1:0] LastK   = KW'(NumSlices - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_a, w_a_d;
  logic [WIDTH-1:0] r_b, w_b_d;
  logic [WIDTH-1:0] r_sum, w_sum_d;
  logic [KW-1:0]    r_k, w_k_d;
  logic             r_carry, w_carry_d;
  logic             r_c_out, w_c_out_d;
  logic             r_ovf, w_ovf_d;

  logic [3:0]       w_slice_a;
  logic [3:0]       w_slice_b;
  logic [3:0]       w_slice_sum;
  logic             w_slice_c;

  // Slice operand select by counter.
  always_comb begin
    w_slice_a = '0;
    w_slice_b = '0;
    for (int unsigned i = 0; i < NumSlices; i++) begin
      if (r_k == KW'(i)) begin
        w_slice_a = r_a[4*i +: 4];
        w_slice_b = r_b[4*i +: 4];
      end
    end
  end

  CarryLookAheadAdder4Bit u_slice (
    .i_a   (w_slice_a),
    .i_b   (w_slice_b),
    .i_c   (r_carry),
    .o_sum (w_slice_sum),
    .o_c   (w_slice_c)
  );

  always_comb begin
    w_state_d = r_state;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_sum_d   = r_sum;
    w_k_d     = r_k;
    w_carry_d = r_carry;
    w_c_out_d = r_c_out;
    w_ovf_d   = r_ovf;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_a_d     = a;
          w_b_d     = sub ? ~b : b;
          w_carry_d = sub ? 1'b1 : c_in;
          w_k_d     = '0;
          w_state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NumSlices; i++) begin
          if (r_k == KW'(i)) begin
            w_sum_d[4*i +: 4] = w_slice_sum;
          end
        end
        w_carry_d = w_slice_c;
        if (r_k == LastK) begin
          w_k_d     = '0;
          w_state_d = StDone;
          w_c_out_d = w_slice_c;
          // Uses the just-assembled MSB so the flag lands together with the final slice.
          w_ovf_d   = (r_a[WIDTH-1] == r_b[WIDTH-1]) & (w_sum_d[WIDTH-1] != r_a[WIDTH-1]);
        end else begin
          w_k_d = r_k + KW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_a     <= w_a_d;
      r_b     <= w_b_d;
      r_sum   <= w_sum_d;
      r_k     <= w_k_d;
      r_carry <= w_carry_d;
      r_c_out <= w_c_out_d;
      r_ovf   <= w_ovf_d;
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16): vector table, scoreboard queue, corner sequences.

module tb_nibble_serial_adder;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         c;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         ovf;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[11];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub);
    exp_t         e;
    logic [W-1:0] bp;
    logic [W:0]   full;
    bp     = msub ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, bp} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
    e.sum  = full[W-1:0];
    e.c    = full[W];
    e.ovf  = (ma[W-1] == bp[W-1]) && (e.sum[W-1] != ma[W-1]);
    return e;
  endfunction

  // Called right after the accept edge; waits for out_valid and scores the result.
  task automatic wait_result(input string name);
    int   lat;
    bit   got;
    exp_t e;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid got 0 expected 1", name);
      if (sbq.size() > 0) void'(sbq.pop_front());
      return;
    end
    check({name, "_latency"}, 64'(lat), 64'd4);
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got result expected none", name);
      return;
    end
    e = sbq.pop_front();
    check({name, "_sum"}, 64'(sum), 64'(e.sum));
    check({name, "_cout"}, 64'(c_out), 64'(e.c));
    check({name, "_ovf"}, 64'(overflow), 64'(e.ovf));
  endtask

  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                        input logic tsub, input string name);
    @(negedge clk);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_;
    c_in     = tcin;
    sub      = tsub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    c_in     = 1'($urandom);
    sub      = 1'($urandom);
    check({name, "_busy"}, 64'(in_ready), 64'd0);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                        input logic tsub, input exp_t e, input string name);
    sbq.push_back(e);
    accept(ta, tb_, tcin, tsub, name);
    wait_result(name);
    @(posedge clk);
    #1;
    check({name, "_idle_ready"}, 64'(in_ready), 64'd1);
    check({name, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_vec(input int idx);
    exp_t e;
    e.sum = vecs[idx].sum;
    e.c   = vecs[idx].c;
    e.ovf = vecs[idx].ovf;
    run_op(vecs[idx].a, vecs[idx].b, vecs[idx].cin, vecs[idx].sub, e,
           $sformatf("vec%0d", idx));
  endtask

  initial begin
    //          a         b        cin   sub   sum       c     ovf
    vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[4]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[9]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    sub       = 1'b0;

    // Reset and idle hold
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("idle_in_ready", 64'(in_ready), 64'd1);
      check("idle_out_valid", 64'(out_valid), 64'd0);
      check("idle_sum", 64'(sum), 64'd0);
      check("idle_cout", 64'(c_out), 64'd0);
      check("idle_ovf", 64'(overflow), 64'd0);
    end

    for (int i = 0; i < 11; i++) run_vec(i);

    // Random operations against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), $sformatf("rand%0d", i));
    end

    // Backpressure: result held while out_ready low, new requests ignored
    out_ready = 1'b0;
    sbq.push_back(model(16'h7FFF, 16'h0001, 1'b0, 1'b0));
    accept(16'h7FFF, 16'h0001, 1'b0, 1'b0, "bp");
    wait_result("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'(i % 2);
      a        = W'($urandom);
      b        = W'($urandom);
      sub      = 1'($urandom);
      @(posedge clk);
      #1;
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_sum", 64'(sum), 64'h8000);
      check("bp_cout", 64'(c_out), 64'd0);
      check("bp_ovf", 64'(overflow), 64'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    run_vec(3);

    // Reset during the second RUN cycle
    accept(16'h1111, 16'h2222, 1'b0, 1'b0, "midrst");
    @(posedge clk);
    #5;
    reset = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_cout", 64'(c_out), 64'd0);
    check("midrst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("midrst_no_valid", 64'(out_valid), 64'd0);
      check("midrst_idle", 64'(in_ready), 64'd1);
    end
    run_vec(6);

    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
